// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage ahead of the 64-bit ALU: 32x64 register file with
// XZR and writeback bypass, B mux, ALU SELECT decode, and a single-entry valid/ready output register.
module alu_operand_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_EN,
  input  logic [4:0]      WB_ADDR,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      RN,
  input  logic [4:0]      RM,
  input  logic [XLEN-1:0] IMM,
  input  logic            USE_IMM,
  input  logic [1:0]      ALUOP,
  input  logic [10:0]     OPCODE,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      SELECT,
  output logic            ILLEGAL
);

  localparam logic [4:0] XZR = 5'(NREGS - 1);

  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_ORR   = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_PASSB = 4'b0111;
  localparam logic [3:0] SEL_ILL   = 4'b1111;

  logic [XLEN-1:0] regFile_q [NREGS];

  logic            wbWrite;
  logic            capture;
  logic [XLEN-1:0] rnVal;
  logic [XLEN-1:0] rmVal;
  logic [XLEN-1:0] opB;
  logic [3:0]      decSel;
  logic            decIll;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      sel_q, sel_d;
  logic            ill_q, ill_d;

  assign wbWrite  = WB_EN && (WB_ADDR != XZR);
  assign IN_READY = !valid_q || OUT_READY;
  assign capture  = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wbWrite) begin
      regFile_q[WB_ADDR] <= WB_DATA;
    end
  end

  // Same-cycle writeback wins over the stale file contents; XZR always reads zero.
  always_comb begin
    rnVal = regFile_q[RN];
    if (RN == XZR) begin
      rnVal = '0;
    end else if (wbWrite && (WB_ADDR == RN)) begin
      rnVal = WB_DATA;
    end
  end

  always_comb begin
    rmVal = regFile_q[RM];
    if (RM == XZR) begin
      rmVal = '0;
    end else if (wbWrite && (WB_ADDR == RM)) begin
      rmVal = WB_DATA;
    end
  end

  assign opB = USE_IMM ? IMM : rmVal;

  always_comb begin
    decSel = SEL_ILL;
    decIll = 1'b0;
    unique case (ALUOP)
      2'b00: decSel = SEL_ADD;
      2'b01: decSel = SEL_PASSB;
      2'b10: begin
        unique case (OPCODE)
          11'b10001011000: decSel = SEL_ADD;
          11'b11001011000: decSel = SEL_SUB;
          11'b10001010000: decSel = SEL_AND;
          11'b10101010000: decSel = SEL_ORR;
          default: begin
            decSel = SEL_ILL;
            decIll = 1'b1;
          end
        endcase
      end
      default: begin
        decSel = SEL_ILL;
        decIll = 1'b1;
      end
    endcase
  end

  // A capture overwrites the entry even while it is being consumed, so there is no bubble.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    ill_d   = ill_q;
    if (capture) begin
      valid_d = 1'b1;
      a_d     = rnVal;
      b_d     = opB;
      sel_d   = decSel;
      ill_d   = decIll;
    end else if (OUT_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 4'b0000;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign SELECT    = sel_q;
  assign ILLEGAL   = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a register-file/handshake model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_EN;
  logic [4:0]  WB_ADDR;
  logic [63:0] WB_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [4:0]  RN;
  logic [4:0]  RM;
  logic [63:0] IMM;
  logic        USE_IMM;
  logic [1:0]  ALUOP;
  logic [10:0] OPCODE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  SELECT;
  logic        ILLEGAL;

  int errors = 0;
  int checks = 0;

  logic [63:0] modelRegs [32];
  logic        expValid = 1'b0;
  logic        pinned   = 1'b0;
  logic [63:0] expA     = '0;
  logic [63:0] expB     = '0;
  logic [3:0]  expSel   = '0;
  logic        expIll   = 1'b0;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  alu_operand_stage dut (
    .CLK(CLK), .RESET(RESET), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .RN(RN), .RM(RM), .IMM(IMM),
    .USE_IMM(USE_IMM), .ALUOP(ALUOP), .OPCODE(OPCODE), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .A(A), .B(B), .SELECT(SELECT), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Returns {illegal, select} straight from the ALU control table.
  function automatic logic [4:0] modelDecode(input logic [1:0] aluop, input logic [10:0] opcode);
    if (aluop == 2'b00) return {1'b0, 4'b0010};
    if (aluop == 2'b01) return {1'b0, 4'b0111};
    if (aluop == 2'b11) return {1'b1, 4'b1111};
    case (opcode)
      OP_ADD:  return {1'b0, 4'b0010};
      OP_SUB:  return {1'b0, 4'b0110};
      OP_AND:  return {1'b0, 4'b0000};
      OP_ORR:  return {1'b0, 4'b0001};
      default: return {1'b1, 4'b1111};
    endcase
  endfunction

  function automatic logic [63:0] modelRead(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (WB_EN && WB_ADDR != 5'd31 && WB_ADDR == idx) return WB_DATA;
    return modelRegs[idx];
  endfunction

  task automatic checkOutput();
    checkVal("out_valid", {63'd0, OUT_VALID}, {63'd0, expValid});
    if (pinned) begin
      checkVal("a", A, expA);
      checkVal("b", B, expB);
      checkVal("select", {60'd0, SELECT}, {60'd0, expSel});
      checkVal("illegal", {63'd0, ILLEGAL}, {63'd0, expIll});
    end
  endtask

  // Runs one clock with the inputs already driven at the preceding negedge.
  task automatic applyStimulus();
    logic        ready;
    logic [4:0]  dec;
    #1;
    ready = !expValid || OUT_READY;
    checkVal("in_ready", {63'd0, IN_READY}, {63'd0, ready});
    if (RESET) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      expValid = 1'b0;
      expA = '0; expB = '0; expSel = '0; expIll = 1'b0;
      pinned = 1'b1;
    end else begin
      if (IN_VALID && ready) begin
        dec      = modelDecode(ALUOP, OPCODE);
        expA     = modelRead(RN);
        expB     = USE_IMM ? IMM : modelRead(RM);
        expSel   = dec[3:0];
        expIll   = dec[4];
        expValid = 1'b1;
        pinned   = 1'b1;
      end else if (OUT_READY) begin
        expValid = 1'b0;
        pinned   = 1'b0;
      end
      if (WB_EN && WB_ADDR != 5'd31) modelRegs[WB_ADDR] = WB_DATA;
    end
    @(posedge CLK);
    #1;
    checkOutput();
    @(negedge CLK);
  endtask

  task automatic setIdle();
    IN_VALID = 1'b0;
    WB_EN    = 1'b0;
  endtask

  task automatic issueOp(input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm,
                         input logic useImm, input logic [1:0] aluop, input logic [10:0] opcode);
    IN_VALID = 1'b1;
    RN = rn; RM = rm; IMM = imm; USE_IMM = useImm; ALUOP = aluop; OPCODE = opcode;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [63:0] data);
    WB_EN = 1'b1; WB_ADDR = addr; WB_DATA = data;
  endtask

  initial begin
    RESET = 1'b1; WB_EN = 0; WB_ADDR = 0; WB_DATA = 0; IN_VALID = 0;
    RN = 0; RM = 0; IMM = 0; USE_IMM = 0; ALUOP = 0; OPCODE = 0; OUT_READY = 0;
    @(negedge CLK);
    applyStimulus();
    applyStimulus();
    checkVal("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    checkVal("rst_a", A, 64'd0);
    checkVal("rst_b", B, 64'd0);
    checkVal("rst_select", {60'd0, SELECT}, 64'd0);
    checkVal("rst_illegal", {63'd0, ILLEGAL}, 64'd0);

    RESET = 1'b0; OUT_READY = 1'b1;
    setIdle();
    #1 checkVal("ready_after_reset", {63'd0, IN_READY}, 64'd1);
    issueOp(5, 0, 0, 0, 2'b00, 0);
    applyStimulus();
    checkVal("cleared_x5", A, 64'd0);
    checkVal("ldst_select", {60'd0, SELECT}, 64'b0010);

    setIdle();
    writeReg(1, 64'd64); applyStimulus();
    writeReg(2, 64'd32); applyStimulus();
    setIdle();

    issueOp(1, 2, 0, 0, 2'b10, OP_SUB); applyStimulus();
    checkVal("sub_a", A, 64'd64);
    checkVal("sub_b", B, 64'd32);
    checkVal("sub_select", {60'd0, SELECT}, 64'b0110);
    issueOp(2, 1, 0, 0, 2'b10, OP_AND); applyStimulus();
    checkVal("and_select", {60'd0, SELECT}, 64'b0000);
    checkVal("and_a", A, 64'd32);
    issueOp(1, 1, 0, 0, 2'b10, OP_ORR); applyStimulus();
    checkVal("orr_select", {60'd0, SELECT}, 64'b0001);
    issueOp(2, 2, 0, 0, 2'b10, OP_ADD); applyStimulus();
    checkVal("add_select", {60'd0, SELECT}, 64'b0010);
    checkVal("b2b_valid", {63'd0, OUT_VALID}, 64'd1);

    issueOp(3, 0, 0, 0, 2'b00, 0);
    writeReg(3, 64'hDEAD); applyStimulus();
    checkVal("bypass_a", A, 64'hDEAD);
    issueOp(31, 31, 0, 0, 2'b00, 0);
    writeReg(31, 64'd7); applyStimulus();
    checkVal("xzr_bypass_a", A, 64'd0);
    checkVal("xzr_bypass_b", B, 64'd0);
    setIdle();
    issueOp(31, 3, 0, 0, 2'b00, 0); applyStimulus();
    checkVal("xzr_after", A, 64'd0);
    checkVal("x3_after", B, 64'hDEAD);

    issueOp(1, 2, 0, 0, 2'b10, OP_SUB); applyStimulus();
    OUT_READY = 1'b0;
    issueOp(2, 1, 0, 0, 2'b10, OP_ADD);
    for (int i = 0; i < 3; i++) begin
      #1 checkVal("stall_in_ready", {63'd0, IN_READY}, 64'd0);
      applyStimulus();
      checkVal("stall_hold_a", A, 64'd64);
      checkVal("stall_hold_sel", {60'd0, SELECT}, 64'b0110);
    end
    OUT_READY = 1'b1;
    applyStimulus();
    checkVal("release_a", A, 64'd32);
    checkVal("release_sel", {60'd0, SELECT}, 64'b0010);
    setIdle();
    applyStimulus();
    checkVal("no_dup_valid", {63'd0, OUT_VALID}, 64'd0);

    issueOp(4, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 2'b01, 0); applyStimulus();
    checkVal("cbz_select", {60'd0, SELECT}, 64'b0111);
    checkVal("cbz_b", B, 64'hFFFF_FFFF_FFFF_FFF8);
    issueOp(1, 2, 0, 0, 2'b10, 11'd0); applyStimulus();
    checkVal("bad_opcode_sel", {60'd0, SELECT}, 64'hF);
    checkVal("bad_opcode_ill", {63'd0, ILLEGAL}, 64'd1);
    issueOp(1, 2, 0, 0, 2'b11, OP_ADD); applyStimulus();
    checkVal("aluop11_ill", {63'd0, ILLEGAL}, 64'd1);

    // Mixed traffic: bypass hits, immediates and intermittent backpressure.
    for (int i = 0; i < 12; i++) begin
      writeReg(5'(4 + i % 4), 64'(i) * 64'h1111_0000_1111);
      issueOp(5'(4 + i % 4), 5'(4 + (i + 1) % 4), 64'(i) - 64'd3, 1'(i % 5 == 0),
              2'(i % 4), (i % 2 == 0) ? OP_ORR : OP_SUB);
      OUT_READY = (i % 3 != 0);
      applyStimulus();
    end

    setIdle(); OUT_READY = 1'b1;
    issueOp(1, 2, 0, 0, 2'b10, OP_SUB); applyStimulus();
    OUT_READY = 1'b0;
    RESET = 1'b1;
    writeReg(1, 64'd99);
    issueOp(2, 2, 0, 0, 2'b00, 0);
    applyStimulus();
    checkVal("reset_drop_valid", {63'd0, OUT_VALID}, 64'd0);
    RESET = 1'b0; OUT_READY = 1'b1;
    setIdle();
    issueOp(1, 1, 0, 0, 2'b00, 0); applyStimulus();
    checkVal("reset_ignores_wb", A, 64'd0);
    setIdle();
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Operand-fetch/issue stage directly upstream of the 64-bit ALU. It holds the 32x64 architectural register file, reads two source registers, selects register or immediate for B, and decodes ALUOp/opcode into the ALU's 4-bit SELECT code. A, B and SELECT are presented to the ALU from a single-entry output register under a valid/ready handshake.

Parameters:
- XLEN, 64, datapath and register width
- NREGS, 32, register count; index NREGS-1 (X31) is XZR

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- WB_EN  in  1  register write enable from writeback
- WB_ADDR  in  5  writeback destination register
- WB_DATA  in  64  writeback data
- IN_VALID  in  1  issue request valid
- IN_READY  out  1  stage can accept a request this cycle
- RN  in  5  source register for A
- RM  in  5  source register for B
- IMM  in  64  sign-extended immediate
- USE_IMM  in  1  1: B = IMM, 0: B = reg[RM]
- ALUOP  in  2  main-control ALU operation class
- OPCODE  in  11  instruction bits [31:21] for R-type decode
- OUT_VALID  out  1  A/B/SELECT valid to ALU
- OUT_READY  in  1  ALU/next stage accepts this cycle
- A  out  64  operand A
- B  out  64  operand B
- SELECT  out  4  ALU control code
- ILLEGAL  out  1  undecodable operation, qualified by OUT_VALID

Behaviour:
- Reset (RESET=1 at a clock edge): all registers cleared to 0; OUT_VALID=0, A=0, B=0, SELECT=4'b0000, ILLEGAL=0; any pending output is dropped; WB_EN and IN_VALID are ignored in that cycle. IN_READY=1 in the cycle after reset is released.
- Register file: write at clock edge when WB_EN=1 and WB_ADDR!=31. Writes to X31 are discarded. Reads of X31 always return 0.
- Write-to-read bypass: if WB_EN=1, WB_ADDR!=31, and WB_ADDR equals RN (resp. RM) in the capture cycle, the captured A (resp. B when USE_IMM=0) is WB_DATA, not the stale register value.
- Handshake: IN_READY = !OUT_VALID || OUT_READY (combinational). Capture = IN_VALID && IN_READY. Latency is 1 cycle: captured operands appear on A/B/SELECT with OUT_VALID=1 at the next edge.
- OUT_VALID next: 1 on capture; else 0 if OUT_READY=1; else hold. While OUT_VALID=1 and OUT_READY=0, A/B/SELECT/ILLEGAL are held stable and IN_READY=0.
- Simultaneous accept and capture (OUT_VALID=1, OUT_READY=1, IN_VALID=1): the new entry replaces the old one with no bubble, sustaining 1 op/cycle.
- SELECT decode, registered with the operands:
  - ALUOP=00 (load/store address): 0010 ADD
  - ALUOP=01 (CBZ): 0111 PASS B
  - ALUOP=10, OPCODE: 10001011000 -> 0010 ADD; 11001011000 -> 0110 SUB; 10001010000 -> 0000 AND; 10101010000 -> 0001 ORR; any other opcode -> 1111 with ILLEGAL=1
  - ALUOP=11: 1111, ILLEGAL=1
- A is always reg[RN] (or bypass). B is IMM when USE_IMM=1 and reg[RM] (or bypass) otherwise. The values are 64-bit with no width conversion.
- A writeback that targets a register already captured does not modify the held output register.

Test Plan:
- RESET=1 for 2 cycles, then release -> OUT_VALID=0, A=B=0, SELECT=0000, ILLEGAL=0, IN_READY=1. Issue RN=5 -> A=0 (file cleared).
- Write X1=64, X2=32. Issue RN=1, RM=2, ALUOP=10, OPCODE=11001011000, OUT_READY=1 -> next cycle OUT_VALID=1, A=64, B=32, SELECT=0110. Repeat with the AND/ORR/ADD opcodes -> SELECT 0000/0001/0010.
- Issue with WB_EN=1, WB_ADDR=3, WB_DATA=0xDEAD in the same cycle as RN=3 -> A=0xDEAD. Repeat with WB_ADDR=31, WB_DATA=7, RN=31 -> A=0, and X31 still reads 0 afterwards.
- OUT_READY=0 with one op captured (A=64), then IN_VALID=1 with new operands -> IN_READY=0, outputs hold A=64 for 3 cycles. Raise OUT_READY -> new op appears the following cycle. Check no loss and no duplication.
- Back-to-back issue of 4 ops with OUT_READY=1 every cycle -> 4 consecutive OUT_VALID cycles in order. ALUOP=01, USE_IMM=1, IMM=-8 -> SELECT=0111, B=0xFFFFFFFFFFFFFFF8.
- ALUOP=10 with OPCODE=0 -> SELECT=1111, ILLEGAL=1. RESET asserted while OUT_VALID=1 and OUT_READY=0 -> OUT_VALID=0 next cycle.
